// File: rtl/skel_pkg.sv
// Shared types and constants for the 3x3 kernel window feeder.
// Neighbour indices give the byte lane of each neighbour in the packed window
// (P1 centre, then clockwise from north, P9 north-west).
package skel_pkg;

    typedef logic [7:0] pixel_t;

    localparam int PIX_W = 8;
    localparam int WIN_W = 72;

    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int P3_IDX = 2;
    localparam int P4_IDX = 3;
    localparam int P5_IDX = 4;
    localparam int P6_IDX = 5;
    localparam int P7_IDX = 6;
    localparam int P8_IDX = 7;
    localparam int P9_IDX = 8;

endpackage

// File: rtl/kernel_line_buffer.sv
// One image row of pixel storage, indexed by column.
// Reads are combinational so the old value is visible in the same cycle it is overwritten.
// Out-of-range indices read as zero and never write, so the memory stays exactly N deep.
module kernel_line_buffer
    import skel_pkg::*;
#(
    parameter int N       = 8,
    parameter int bitSize = 6
) (
    input  logic           clk,
    input  logic [bitSize:0] idx,
    input  logic           wr_en,
    input  pixel_t         wr_data,
    output pixel_t         rd_data
);

    localparam int CW = bitSize + 1;
    localparam int IW = $clog2(N);

    pixel_t mem [N];
    logic   in_range;

    assign in_range = (idx < CW'(N));
    assign rd_data  = in_range ? mem[idx[IW-1:0]] : '0;

    // Store the incoming pixel at the current column slot.
    always_ff @(posedge clk) begin
        if (wr_en && in_range) begin
            mem[idx[IW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/kernel_window_feeder.sv
// Raster-stream 3x3 window generator feeding the per-pixel kernel units.
// Pixels arrive row-major, one per handshake; two line buffers supply the rows above,
// and a 3x3 shift window produces one neighbourhood per interior pixel.
// Optional feature: define BINARIZE_EN to squash each incoming pixel to 0/1.
module kernel_window_feeder
    import skel_pkg::*;
#(
    parameter int N       = 8,
    parameter int bitSize = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIN_W-1:0]   out_win,
    output logic [bitSize:0]   out_addr,
    output logic               out_last
);

    localparam int CW = bitSize + 1;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TWO  = CW'(2);
    localparam logic [CW-1:0] NW   = CW'(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0]    col;
    logic [CW-1:0]    row;
    logic             acc;
    logic             emit;
    logic             last_pix;
    pixel_t           pix;
    pixel_t           rd0;
    pixel_t           rd1;
    pixel_t           win [3][3];
    pixel_t           sh  [3][3];
    logic [WIN_W-1:0] win_flat;
    logic [CW-1:0]    addr_calc;

    // A single output register with no skid: a new pixel is only taken when
    // the output slot is empty or being drained on this same edge.
    assign in_ready = ~out_valid | out_ready;
    assign acc      = in_valid & in_ready;

`ifdef BINARIZE_EN
    assign pix = (in_data != 8'd0) ? 8'd1 : 8'd0;
`else
    assign pix = in_data;
`endif

    // lb0 holds the previous row, lb1 the row before that; the value leaving lb0
    // cascades into lb1 at the same column.
    kernel_line_buffer #(.N(N), .bitSize(bitSize)) lb0 (
        .clk     (clk),
        .idx     (col),
        .wr_en   (acc),
        .wr_data (pix),
        .rd_data (rd0)
    );

    kernel_line_buffer #(.N(N), .bitSize(bitSize)) lb1 (
        .clk     (clk),
        .idx     (col),
        .wr_en   (acc),
        .wr_data (rd0),
        .rd_data (rd1)
    );

    assign emit      = acc && (row >= TWO) && (col >= TWO);
    assign last_pix  = (row == LAST) && (col == LAST);
    assign addr_calc = (row - ONE) * NW + (col - ONE);

    // Window as it will look after this pixel: shift left, new column on the right.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            sh[r][0] = win[r][1];
            sh[r][1] = win[r][2];
            sh[r][2] = '0;
        end
        sh[0][2] = rd1;
        sh[1][2] = rd0;
        sh[2][2] = pix;
    end

    // Pack the post-shift window into neighbour order around the centre.
    always_comb begin
        win_flat = '0;
        win_flat[P1_IDX*PIX_W +: PIX_W] = sh[1][1];
        win_flat[P2_IDX*PIX_W +: PIX_W] = sh[0][1];
        win_flat[P3_IDX*PIX_W +: PIX_W] = sh[0][2];
        win_flat[P4_IDX*PIX_W +: PIX_W] = sh[1][2];
        win_flat[P5_IDX*PIX_W +: PIX_W] = sh[2][2];
        win_flat[P6_IDX*PIX_W +: PIX_W] = sh[2][1];
        win_flat[P7_IDX*PIX_W +: PIX_W] = sh[2][0];
        win_flat[P8_IDX*PIX_W +: PIX_W] = sh[1][0];
        win_flat[P9_IDX*PIX_W +: PIX_W] = sh[0][0];
    end

    // Window contents are don't-care until refilled, so they carry no reset.
    always_ff @(posedge clk) begin
        if (acc) begin
            win <= sh;
        end
    end

    // Raster position; the last pixel of a frame wraps straight into the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end

    // Output register: load on an interior pixel, retire on out_ready, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= '0;
            out_addr  <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_last  <= last_pix;
            out_win   <= win_flat;
            out_addr  <= addr_calc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
